mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port if_req, input, 1, instruction-fetch request, level, held until if_done.
REQ-004 SHALL have port if_addr, input, 32, fetch byte address, stable while if_req is high.
REQ-005 SHALL have port if_data, output, 32, fetched word, little-endian, valid when if_done=1.
REQ-006 SHALL have port if_done, output, 1, one-cycle completion pulse for a fetch.
REQ-007 SHALL have port mm_req, input, 1, MEM-stage request, level, held until mm_done.
REQ-008 SHALL have port mm_we, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port mm_len, input, 2, access size: 00 = byte, 01 = half, 10 = word, 11 = word.
REQ-010 SHALL have port mm_addr, input, 32, MEM byte address.
REQ-011 SHALL have port mm_wdata, input, 32, store data; low mm_len bytes are used.
REQ-012 SHALL have port mm_rdata, output, 32, load data, zero-extended, valid when mm_done=1.
REQ-013 SHALL have port mm_done, output, 1, one-cycle completion pulse for a MEM access.
REQ-014 SHALL have port ram_a, output, 32, RAM byte address.
REQ-015 SHALL have port ram_dout, output, 8, RAM write byte.
REQ-016 SHALL have port ram_wr, output, 1, RAM write strobe.
REQ-017 SHALL have port ram_din, input, 8, RAM read byte, valid one cycle after its address.
REQ-018 SHALL have port stl_if, output, 1, stall for IF/ID stages.
REQ-019 SHALL have port stl_mm, output, 1, stall for EX/MEM and earlier stages.

Function
REQ-020 SHALL implement states IDLE, IF_XFER and MM_XFER, with a 3-bit byte counter cnt and a 32-bit assembly register.
REQ-021 In IDLE, SHALL grant MM when mm_req=1, else IF when if_req=1; on a simultaneous request, MM SHALL win.
REQ-022 In IDLE, SHALL not grant a requester whose done output is high in that cycle.
REQ-023 On grant, SHALL latch the address, length (N = 1, 2 or 4; IF is always 4), direction and write data, and set cnt=0.
REQ-024 A read transfer SHALL drive ram_a = base+cnt with ram_wr=0, and at cnt>=1 SHALL capture ram_din into byte cnt-1.
REQ-025 A read transfer SHALL end in the cycle cnt==N, after capturing the last byte, so a read takes N+1 cycles.
REQ-026 A write transfer SHALL drive ram_a = base+cnt, ram_dout = wdata byte cnt and ram_wr=1 for cnt = 0..N-1, so a write takes N cycles.
REQ-027 Address addition SHALL be modulo 2^32, so 0xFFFFFFFF+1 = 0x00000000.
REQ-028 At the end of a transfer, SHALL return to IDLE and, in the next cycle, pulse the owner's done for one cycle with the data register valid.
REQ-029 A granted transfer SHALL not be preempted.
REQ-030 Outside XFER states, ram_wr SHALL be 0.
REQ-031 stl_mm SHALL equal mm_req & ~mm_done.
REQ-032 stl_if SHALL equal stl_mm | (if_req & ~if_done); both stalls are combinational.
REQ-033 if_data and mm_rdata SHALL hold their last value until the next completion of the same requester.

Reset
REQ-034 While rst_n=0, the block SHALL be in IDLE with cnt=0, and if_data, mm_rdata, ram_a, ram_dout, ram_wr, if_done and mm_done all 0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer immediately, with no done pulse and no further ram_wr.
REQ-036 The first grant after rst_n rises SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-037 SHALL test IF-only: if_addr=0x100 and RAM[0x100..0x103] = 11 22 33 44 -> ram_a sequence 0x100..0x103, and if_done after 6 cycles with if_data=0x44332211.
REQ-038 SHALL test simultaneous requests: if_req=1 and mm_req=1 (load word at 0x200) in the same cycle -> MM served first with mm_done, then IF; stl_if stays high throughout.
REQ-039 SHALL test a byte store: mm_we=1, mm_len=00, mm_addr=0x8, mm_wdata=0xAABBCCDD -> exactly one ram_wr cycle with ram_a=0x8 and ram_dout=0xDD, then mm_done.
REQ-040 SHALL test a halfword load at mm_addr=0xFFFFFFFF -> ram_a sequence 0xFFFFFFFF then 0x00000000, and mm_rdata=0x0000_{RAM[0]}{RAM[FFFFFFFF]}.
REQ-041 SHALL test reset: rst_n pulsed low at cnt=2 of a word store -> ram_wr drops at once, no mm_done, and the next request restarts at cnt=0.
REQ-042 SHALL test back-to-back: mm_req held through mm_done and a new access presented afterward -> no re-grant in the mm_done cycle, and the new access is granted on the following cycle.

Source files
------------

// File: rtl/mem_arb.sv
// Byte-serial arbiter that shares one 8-bit RAM port between instruction fetch and the MEM stage.
// MM wins ties. A granted transfer runs to completion. Done pulses one cycle after returning to IDLE.
module mem_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        mm_req,
  input  logic        mm_we,
  input  logic [1:0]  mm_len,
  input  logic [31:0] mm_addr,
  input  logic [31:0] mm_wdata,
  output logic [31:0] mm_rdata,
  output logic        mm_done,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic        stl_if,
  output logic        stl_mm
);

  typedef enum logic [1:0] {IDLE, IF_XFER, MM_XFER} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic        we_q, we_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mm_rdata_q, mm_rdata_d;
  logic        if_done_q, if_done_d;
  logic        mm_done_q, mm_done_d;

  logic        in_xfer;
  logic        xfer_last;
  logic [1:0]  rd_bidx;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign in_xfer   = (state_q != IDLE);
  // Reads need one extra cycle because ram_din lags its address by a cycle.
  assign xfer_last = we_q ? (cnt_q == (n_q - 3'd1)) : (cnt_q == n_q);
  assign rd_bidx   = cnt_q[1:0] - 2'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    we_d       = we_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    if_data_d  = if_data_q;
    mm_rdata_d = mm_rdata_q;
    if_done_d  = 1'b0;
    mm_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A requester still holds req during its own done cycle; skip it then.
        if (mm_req && !mm_done_q) begin
          state_d = MM_XFER;
          base_d  = mm_addr;
          we_d    = mm_we;
          wdata_d = mm_wdata;
          n_d     = len_to_n(mm_len);
          cnt_d   = 3'd0;
          asm_d   = 32'd0;
        end else if (if_req && !if_done_q) begin
          state_d = IF_XFER;
          base_d  = if_addr;
          we_d    = 1'b0;
          n_d     = 3'd4;
          cnt_d   = 3'd0;
          asm_d   = 32'd0;
        end
      end
      IF_XFER, MM_XFER: begin
        if (!we_q && (cnt_q != 3'd0)) begin
          asm_d[{rd_bidx, 3'b000} +: 8] = ram_din;
        end
        if (xfer_last) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          if (state_q == IF_XFER) begin
            if_done_d = 1'b1;
            if_data_d = asm_d;
          end else begin
            mm_done_d  = 1'b1;
            mm_rdata_d = asm_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      we_q       <= 1'b0;
      if_data_q  <= 32'd0;
      mm_rdata_q <= 32'd0;
      if_done_q  <= 1'b0;
      mm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      we_q       <= we_d;
      if_data_q  <= if_data_d;
      mm_rdata_q <= mm_rdata_d;
      if_done_q  <= if_done_d;
      mm_done_q  <= mm_done_d;
    end
  end

  // Datapath registers are only observed while a transfer owns them.
  always_ff @(posedge clk) begin
    base_q  <= base_d;
    wdata_q <= wdata_d;
    asm_q   <= asm_d;
  end

  assign ram_a    = in_xfer ? (base_q + {29'd0, cnt_q}) : 32'd0;
  assign ram_wr   = in_xfer && we_q && (cnt_q < n_q);
  assign ram_dout = (in_xfer && we_q) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;

  assign if_data  = if_data_q;
  assign mm_rdata = mm_rdata_q;
  assign if_done  = if_done_q;
  assign mm_done  = mm_done_q;

  assign stl_mm   = mm_req & ~mm_done_q;
  assign stl_if   = stl_mm | (if_req & ~if_done_q);

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: byte RAM model plus a transaction-level reference (address sequence, data, latency, stalls).
// Directed scenarios first, then randomized single and simultaneous requests.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mm_req;
  logic        mm_we;
  logic [1:0]  mm_len;
  logic [31:0] mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_done;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        stl_if;
  logic        stl_mm;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;

  logic [31:0] last_if;
  logic [31:0] last_mm;
  bit          mm_known;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_data  (if_data),
    .if_done  (if_done),
    .mm_req   (mm_req),
    .mm_we    (mm_we),
    .mm_len   (mm_len),
    .mm_addr  (mm_addr),
    .mm_wdata (mm_wdata),
    .mm_rdata (mm_rdata),
    .mm_done  (mm_done),
    .ram_a    (ram_a),
    .ram_dout (ram_dout),
    .ram_wr   (ram_wr),
    .ram_din  (ram_din),
    .stl_if   (stl_if),
    .stl_mm   (stl_mm)
  );

  // RAM aliased on the low 12 address bits; read data is one cycle late.
  always @(posedge clk) begin
    if (ram_wr) mem[ram_a[11:0]] <= ram_dout;
    else if (pre_we) mem[pre_a] <= pre_d;
    ram_din <= mem[ram_a[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    logic [31:0] ai;
    r = 32'd0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      r  = r | (32'(mem[ai[11:0]]) << (8 * i));
    end
    return r;
  endfunction

  task automatic chk_stalls(input bit ifd, input bit mmd);
    bit e_mm;
    bit e_if;
    e_mm = mm_req & ~mmd;
    e_if = e_mm | (if_req & ~ifd);
    chk("stl_mm", 32'(stl_mm), 32'(e_mm));
    chk("stl_if", 32'(stl_if), 32'(e_if));
  endtask

  // Called at the negedge where the request is presented; grant is expected at the next posedge.
  task automatic check_xfer(input bit is_if, input bit we, input int n,
                            input logic [31:0] addr, input logic [31:0] wdata);
    int          len_c;
    logic [31:0] exp_rd;
    logic [31:0] a_k;
    len_c  = we ? n : n + 1;
    exp_rd = we ? 32'd0 : model_read(addr, n);
    for (int k = 0; k < len_c; k++) begin
      @(negedge clk);
      a_k = addr + 32'(k);
      chk("ram_wr", 32'(ram_wr), 32'(we));
      if (k < n) chk("ram_a", ram_a, a_k);
      if (we) chk("ram_dout", 32'(ram_dout), 32'(wdata[8*k +: 8]));
      chk("if_done_busy", 32'(if_done), 32'd0);
      chk("mm_done_busy", 32'(mm_done), 32'd0);
      chk_stalls(1'b0, 1'b0);
    end
    @(negedge clk);
    chk("if_done", 32'(if_done), 32'(is_if));
    chk("mm_done", 32'(mm_done), 32'(!is_if));
    chk("ram_wr_idle", 32'(ram_wr), 32'd0);
    chk_stalls(is_if, !is_if);
    if (is_if) begin
      chk("if_data", if_data, exp_rd);
      last_if = exp_rd;
      if (mm_known) chk("mm_rdata_hold", mm_rdata, last_mm);
    end else begin
      chk("if_data_hold", if_data, last_if);
      if (!we) begin
        chk("mm_rdata", mm_rdata, exp_rd);
        last_mm  = exp_rd;
        mm_known = 1'b1;
      end else begin
        mm_known = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=%08h exp=%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] a2;
    logic [31:0] wd;
    logic [1:0]  len;
    int          n;
    int          kind;
    bit          we;

    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0;
    mm_req = 1'b0; mm_we = 1'b0; mm_len = 2'd0; mm_addr = 32'd0; mm_wdata = 32'd0;
    pre_we = 1'b0; pre_a = 12'd0; pre_d = 8'd0;
    last_if = 32'd0; last_mm = 32'd0; mm_known = 1'b1;

    for (int i = 0; i < 4096; i++) begin
      a = 32'(i);
      poke(a[11:0], a[7:0] ^ a[11:4] ^ 8'h5A);
    end
    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    poke(12'h200, 8'hEF); poke(12'h201, 8'hBE); poke(12'h202, 8'hAD); poke(12'h203, 8'hDE);
    poke(12'hFFF, 8'hA5); poke(12'h000, 8'h3C);

    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mm_rdata", mm_rdata, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_mm_done", 32'(mm_done), 32'd0);

    // IF-only fetch, requested while still in reset.
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("rst_no_grant", ram_a, 32'd0);
    rst_n = 1'b1;
    check_xfer(1'b1, 1'b0, 4, 32'h100, 32'd0);
    chk("if_word", if_data, 32'h44332211);
    if_req = 1'b0;
    @(negedge clk);

    // Simultaneous requests: MM first, then IF.
    if_req = 1'b1; if_addr = 32'h300;
    mm_req = 1'b1; mm_we = 1'b0; mm_len = 2'b10; mm_addr = 32'h200;
    check_xfer(1'b0, 1'b0, 4, 32'h200, 32'd0);
    chk("sim_mm_word", mm_rdata, 32'hDEADBEEF);
    mm_req = 1'b0;
    check_xfer(1'b1, 1'b0, 4, 32'h300, 32'd0);
    if_req = 1'b0;
    @(negedge clk);

    // Byte store.
    mm_req = 1'b1; mm_we = 1'b1; mm_len = 2'b00; mm_addr = 32'h8; mm_wdata = 32'hAABBCCDD;
    check_xfer(1'b0, 1'b1, 1, 32'h8, 32'hAABBCCDD);
    mm_req = 1'b0;
    chk("byte_store_mem", 32'(mem[12'h008]), 32'h000000DD);
    @(negedge clk);

    // Halfword load wrapping past the top of the address space.
    mm_req = 1'b1; mm_we = 1'b0; mm_len = 2'b01; mm_addr = 32'hFFFFFFFF;
    check_xfer(1'b0, 1'b0, 2, 32'hFFFFFFFF, 32'd0);
    chk("half_wrap", mm_rdata, 32'h00003CA5);
    mm_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a word store.
    mm_req = 1'b1; mm_we = 1'b1; mm_len = 2'b10; mm_addr = 32'h40; mm_wdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("pre_rst_wr", 32'(ram_wr), 32'd1);
      chk("pre_rst_a", ram_a, 32'h40 + 32'(k));
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr", 32'(ram_wr), 32'd0);
    chk("rst_mid_a", ram_a, 32'd0);
    chk("rst_mid_done", 32'(mm_done), 32'd0);
    mm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_if = 32'd0; last_mm = 32'd0; mm_known = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(mm_done), 32'd0);
      chk("post_rst_wr", 32'(ram_wr), 32'd0);
    end
    chk("post_rst_rdata", mm_rdata, 32'd0);
    mm_req = 1'b1;
    check_xfer(1'b0, 1'b1, 4, 32'h40, 32'h12345678);
    mm_req = 1'b0;
    @(negedge clk);

    // Back-to-back: request held through done, new access presented right after.
    mm_req = 1'b1; mm_we = 1'b0; mm_len = 2'b11; mm_addr = 32'h200;
    check_xfer(1'b0, 1'b0, 4, 32'h200, 32'd0);
    mm_we = 1'b1; mm_len = 2'b01; mm_addr = 32'h60; mm_wdata = 32'h0000CAFE;
    @(negedge clk);
    chk("b2b_no_regrant_wr", 32'(ram_wr), 32'd0);
    chk("b2b_no_regrant_a", ram_a, 32'd0);
    chk("b2b_gap_done", 32'(mm_done), 32'd0);
    chk("b2b_gap_stl", 32'(stl_mm), 32'd1);
    check_xfer(1'b0, 1'b1, 2, 32'h60, 32'h0000CAFE);
    mm_req = 1'b0;
    @(negedge clk);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      a2   = $urandom;
      wd   = $urandom;
      len  = 2'($urandom_range(0, 3));
      n    = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
      we   = (kind == 2) || ((kind == 3) && ($urandom_range(0, 1) == 1));
      if (kind == 0) begin
        if_req = 1'b1; if_addr = a;
        check_xfer(1'b1, 1'b0, 4, a, 32'd0);
        if_req = 1'b0;
      end else begin
        mm_req = 1'b1; mm_we = we; mm_len = len; mm_addr = a; mm_wdata = wd;
        if (kind == 3) begin
          if_req = 1'b1; if_addr = a2;
        end
        check_xfer(1'b0, we, n, a, wd);
        mm_req = 1'b0;
        if (kind == 3) begin
          check_xfer(1'b1, 1'b0, 4, a2, 32'd0);
          if_req = 1'b0;
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
